// File: rtl/i2c_target.sv
// i2c_target: clock-oversampled I2C responder with a DEPTH-byte register file.
// Bytes written over the bus are committed to the register file and echoed on
// a side channel. A local port reads the register file combinationally.
// Handshake: wr_strobe is a valid-only pulse (no ready). wr_addr/wr_data are
// valid in the strobe cycle and hold until the next strobe. The bus side
// acknowledges a byte by holding SDA low from the 8th SCL fall to the 9th.
module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h50,
  parameter int unsigned DEPTH       = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     SCL,
  inout  wire                      SDA,
  output logic                     busy,
  output logic                     wr_strobe,
  output logic [$clog2(DEPTH)-1:0] wr_addr,
  output logic [7:0]               wr_data,
  input  logic [$clog2(DEPTH)-1:0] reg_rd_addr,
  output logic [7:0]               reg_rd_data
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT
  } state_e;

  // Synchroniser and history flops for both bus lines
  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  // Protocol state
  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            rw_q, rw_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            sda_low_q, sda_low_d;
  logic            busy_q, busy_d;
  logic            wr_strobe_q, wr_strobe_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [7:0]      regs_q [DEPTH];
  logic [7:0]      regs_d [DEPTH];

  logic            scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]      rx_byte;
  logic [AW-1:0]   ptr_inc;

  // Edge and bus-condition detection on the synchronised copies
  assign scl_rise  = scl_sync_q & ~scl_hist_q;
  assign scl_fall  = ~scl_sync_q & scl_hist_q;
  assign start_det = scl_sync_q & scl_hist_q & sda_hist_q & ~sda_sync_q;
  assign stop_det  = scl_sync_q & scl_hist_q & ~sda_hist_q & sda_sync_q;
  assign rx_byte   = {shift_q[6:0], sda_sync_q};
  assign ptr_inc   = ptr_q + AW'(1);

  // Two-flop synchroniser plus history flop; idle bus level after reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= SCL;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= SDA;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
    end
  end

  // Next-state logic: START beats STOP, both beat per-state bit handling
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    ptr_d       = ptr_q;
    sda_low_d   = sda_low_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;

    if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      shift_d   = '0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else if (stop_det) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      shift_d   = '0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rw_d = rx_byte[0];
              if (rx_byte[7:1] == TARGET_ADDR) begin
                state_d = ST_ADDR_ACK;
                busy_d  = 1'b1;
              end else begin
                state_d = ST_WAIT;
              end
            end
          end
        end
        ST_PTR: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ptr_d   = rx_byte[AW-1:0];
              state_d = ST_PTR_ACK;
            end
          end
        end
        ST_WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              regs_d[ptr_q] = rx_byte;
              wr_strobe_d   = 1'b1;
              wr_addr_d     = ptr_q;
              wr_data_d     = rx_byte;
              ptr_d         = ptr_inc;
              state_d       = ST_WDATA_ACK;
            end
          end
        end
        // ACK phases: first SCL fall pulls SDA low, second fall releases it
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else if (rw_q) begin
              state_d   = ST_RDATA;
              shift_d   = regs_q[ptr_q];
              sda_low_d = ~regs_q[ptr_q][7];
              bit_cnt_d = '0;
            end else begin
              state_d   = ST_PTR;
              sda_low_d = 1'b0;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_low_q) begin
              sda_low_d = 1'b1;
            end else begin
              state_d   = ST_WDATA;
              sda_low_d = 1'b0;
            end
          end
        end
        // Read data: MSB already on the bus, next bit presented on each fall
        ST_RDATA: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              sda_low_d = 1'b0;
              state_d   = ST_RDATA_ACK;
            end else begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_low_d = ~shift_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda_sync_q) begin
              ptr_d   = ptr_inc;
              shift_d = regs_q[ptr_inc];
            end else begin
              state_d = ST_WAIT;
              busy_d  = 1'b0;
            end
          end else if (scl_fall) begin
            state_d   = ST_RDATA;
            sda_low_d = ~shift_q[7];
            bit_cnt_d = '0;
          end
        end
        ST_WAIT: begin
          sda_low_d = 1'b0;
          busy_d    = 1'b0;
        end
        ST_IDLE: begin
          sda_low_d = 1'b0;
        end
        default: begin
          state_d   = ST_IDLE;
          sda_low_d = 1'b0;
          busy_d    = 1'b0;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      ptr_q       <= '0;
      sda_low_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      regs_q      <= '{default: 8'h00};
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      ptr_q       <= ptr_d;
      sda_low_q   <= sda_low_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      regs_q      <= regs_d;
    end
  end

  assign SDA         = sda_low_q ? 1'b0 : 1'bz;
  assign busy        = busy_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign reg_rd_data = regs_q[reg_rd_addr];

endmodule
